// File: rtl/cmd_router_nport.sv
// Address-window command router: one host port fanned out to NUM_TARGETS target ports,
// with error acks on decode miss / ack timeout. Define CMD_ROUTER_STATS_EN for error counters.
module cmd_router_nport #(
  parameter int          NUM_TARGETS            = 8,
  parameter int          HOST_ADDRESS_BITS      = 26,
  parameter int          TARGET_ADDRESS_BITS    = 16,
  parameter int          HOST_DATA_BITS         = 32,
  parameter int          P_CMD_ACK_TIMEOUT_CLKS = 16,
  parameter logic [31:0] P_ERR_RDATA            = 32'hDEAD_BEEF,
  localparam int         SEL_BITS               = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                                               i_sys_clk,
  input  logic                                               i_sys_rst_n,
  // host port
  input  logic                                               i_cmd_sel,
  input  logic                                               i_cmd_rd_wr_n,
  input  logic [HOST_ADDRESS_BITS-1:0]                       i_cmd_byte_addr,
  input  logic [HOST_DATA_BITS-1:0]                          i_cmd_wdata,
  output logic                                               o_cmd_ack,
  output logic [HOST_DATA_BITS-1:0]                          o_cmd_rdata,
  // target ports
  output logic [NUM_TARGETS-1:0]                             o_tgt_sel,
  output logic [NUM_TARGETS-1:0]                             o_tgt_rd_wr_n,
  output logic [NUM_TARGETS-1:0][HOST_ADDRESS_BITS-1:0]      o_tgt_byte_addr,
  output logic [NUM_TARGETS-1:0][HOST_DATA_BITS-1:0]         o_tgt_wdata,
  input  logic [NUM_TARGETS-1:0]                             i_tgt_ack,
  input  logic [NUM_TARGETS-1:0][HOST_DATA_BITS-1:0]         i_tgt_rdata,
  // error reporting
  output logic                                               o_err_timeout,
  output logic                                               o_err_decode,
  output logic [SEL_BITS:0]                                  o_last_err_tgt,
  output logic [15:0]                                        o_timeout_cnt,
  output logic [15:0]                                        o_decode_err_cnt
);

  localparam int CNT_W = $clog2(P_CMD_ACK_TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_RESP,
    S_ERR_RESP
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [NUM_TARGETS-1:0]        r_sel;
  logic                          r_rd_wr_n;
  logic [HOST_ADDRESS_BITS-1:0]  r_addr;
  logic [HOST_DATA_BITS-1:0]     r_wdata;
  logic [SEL_BITS-1:0]           r_tgt;
  logic [CNT_W-1:0]              r_to_cnt;
  logic [HOST_DATA_BITS-1:0]     r_rdata;
  logic                          r_err_timeout;
  logic                          r_err_decode;
  logic [SEL_BITS:0]             r_last_err_tgt;

  logic [SEL_BITS-1:0]           w_dec_tgt;
  logic                          w_hit;
  logic                          w_capture;
  logic                          w_ack_hit;
  logic                          w_timeout;
  logic                          w_miss;

  // Hit needs every address bit above the select field clear and an existing target index.
  assign w_dec_tgt = i_cmd_byte_addr[TARGET_ADDRESS_BITS +: SEL_BITS];
  assign w_hit     = ((i_cmd_byte_addr >> (TARGET_ADDRESS_BITS + SEL_BITS)) == '0) &&
                     ({1'b0, w_dec_tgt} < (SEL_BITS+1)'(NUM_TARGETS));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_ack_hit    = 1'b0;
    w_timeout    = 1'b0;
    w_miss       = 1'b0;
    o_cmd_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_sel) begin
          w_capture = 1'b1;
          if (w_hit) begin
            w_state_next = S_WAIT_ACK;
          end else begin
            w_miss       = 1'b1;
            w_state_next = S_ERR_RESP;
          end
        end
      end
      S_WAIT_ACK: begin
        // An ack in the final counted cycle still wins over the timeout.
        if (i_tgt_ack[r_tgt]) begin
          w_ack_hit    = 1'b1;
          w_state_next = S_RESP;
        end else if (r_to_cnt == CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = S_ERR_RESP;
        end
      end
      S_RESP, S_ERR_RESP: begin
        o_cmd_ack    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_sel          <= '0;
      r_rd_wr_n      <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_tgt          <= '0;
      r_to_cnt       <= '0;
      r_rdata        <= '0;
      r_err_timeout  <= 1'b0;
      r_err_decode   <= 1'b0;
      r_last_err_tgt <= '0;
    end else begin
      r_sel <= '0;
      if (w_capture) begin
        if (w_hit) begin
          r_sel[w_dec_tgt] <= 1'b1;
        end
        r_rd_wr_n <= i_cmd_rd_wr_n;
        r_addr    <= HOST_ADDRESS_BITS'(i_cmd_byte_addr[TARGET_ADDRESS_BITS-1:0]);
        r_wdata   <= i_cmd_wdata;
        r_tgt     <= w_dec_tgt;
      end
      if (w_capture) begin
        r_to_cnt <= '0;
      end else if (r_state == S_WAIT_ACK) begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
      // Host rdata only changes when a response is launched, so it holds between acks.
      if (w_ack_hit) begin
        r_rdata <= i_tgt_rdata[r_tgt];
      end else if (w_miss || w_timeout) begin
        r_rdata <= HOST_DATA_BITS'(P_ERR_RDATA);
      end
      r_err_timeout <= w_timeout;
      r_err_decode  <= w_miss;
      if (w_miss) begin
        r_last_err_tgt <= {1'b1, {SEL_BITS{1'b0}}};
      end else if (w_timeout) begin
        r_last_err_tgt <= {1'b0, r_tgt};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
      assign o_tgt_sel[gi]       = r_sel[gi];
      assign o_tgt_rd_wr_n[gi]   = r_rd_wr_n;
      assign o_tgt_byte_addr[gi] = r_addr;
      assign o_tgt_wdata[gi]     = r_wdata;
    end
  endgenerate

  assign o_cmd_rdata    = r_rdata;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_decode   = r_err_decode;
  assign o_last_err_tgt = r_last_err_tgt;

`ifdef CMD_ROUTER_STATS_EN
  logic [15:0] r_timeout_cnt;
  logic [15:0] r_decode_err_cnt;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_timeout_cnt    <= '0;
      r_decode_err_cnt <= '0;
    end else begin
      if (w_timeout && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end
      if (w_miss && (r_decode_err_cnt != 16'hFFFF)) begin
        r_decode_err_cnt <= r_decode_err_cnt + 16'd1;
      end
    end
  end

  assign o_timeout_cnt    = r_timeout_cnt;
  assign o_decode_err_cnt = r_decode_err_cnt;
`else
  assign o_timeout_cnt    = 16'h0;
  assign o_decode_err_cnt = 16'h0;
`endif

endmodule
